// File: rtl/bsg_link_osdr_tx_ctrl_if.sv
// Core-side and PHY-side signal bundle for the OSDR transmit controller.
// The controller attaches through the slave modport; the driving side uses master.
interface bsg_link_osdr_tx_ctrl_if #(
  parameter int unsigned width_p   = 16,
  parameter int unsigned credits_p = 16
);
  localparam int unsigned CredW = $clog2(credits_p + 1);

  logic               link_enable_i;
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               token_i;
  logic               phy_reset_o;
  logic [width_p:0]   phy_data_o;
  logic               link_up_o;
  logic [CredW-1:0]   credits_o;
  logic               overflow_o;

  modport master (
    output link_enable_i, v_i, data_i, token_i,
    input  ready_o, phy_reset_o, phy_data_o, link_up_o, credits_o, overflow_o
  );

  modport slave (
    input  link_enable_i, v_i, data_i, token_i,
    output ready_o, phy_reset_o, phy_data_o, link_up_o, credits_o, overflow_o
  );
endinterface

// File: rtl/bsg_link_osdr_tx_ctrl.sv
// OSDR transmit controller: sequences PHY reset and clock-only warm-up, then meters
// core sends against downstream credits returned as a toggling token wire.
module bsg_link_osdr_tx_ctrl #(
  parameter int unsigned width_p                = 16,
  parameter int unsigned credits_p              = 16,
  parameter int unsigned lg_credit_decimation_p = 2,
  parameter int unsigned phy_reset_cycles_p     = 4,
  parameter int unsigned warmup_cycles_p        = 32
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  bsg_link_osdr_tx_ctrl_if.slave  link
);
  localparam int unsigned CredW  = $clog2(credits_p + 1);
  localparam int unsigned MaxCyc = (phy_reset_cycles_p > warmup_cycles_p) ?
                                   phy_reset_cycles_p : warmup_cycles_p;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned Dec    = 1 << lg_credit_decimation_p;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPhyRst = 2'd1;
  localparam logic [1:0] StWarmup = 2'd2;
  localparam logic [1:0] StActive = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CredW-1:0] credits_q, credits_d;
  logic             overflow_q, overflow_d;
  logic [width_p:0] phy_data_q, phy_data_d;
  logic             sync1_q, sync2_q, sync3_q;

  logic             active, ready, hs, pulse, warmup_entry;
  logic [CredW:0]   sum;

  // Single down-counter shared by the two timed states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (link.link_enable_i) begin
          state_d = StPhyRst;
          cnt_d   = CntW'(phy_reset_cycles_p - 1);
        end
      end
      StPhyRst: begin
        if (cnt_q == '0) begin
          state_d = StWarmup;
          cnt_d   = CntW'(warmup_cycles_p - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWarmup: begin
        if (cnt_q == '0) state_d = StActive;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StActive: ;
      default: state_d = StIdle;
    endcase
    if (!link.link_enable_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  assign active       = (state_q == StActive);
  assign ready        = active & link.link_enable_i & (credits_q != '0);
  assign hs           = link.v_i & ready;
  assign pulse        = sync2_q ^ sync3_q;
  assign warmup_entry = (state_q == StPhyRst) && (state_d == StWarmup);

  // One extra bit so an over-return is visible before clamping.
  assign sum = {1'b0, credits_q} - {{CredW{1'b0}}, hs} + (pulse ? (CredW+1)'(Dec) : '0);

  always_comb begin
    credits_d  = credits_q;
    overflow_d = overflow_q;
    if (warmup_entry) begin
      credits_d  = CredW'(credits_p);
      overflow_d = 1'b0;
    end else if (active) begin
      if (sum > (CredW+1)'(credits_p)) begin
        credits_d  = CredW'(credits_p);
        overflow_d = 1'b1;
      end else begin
        credits_d = sum[CredW-1:0];
      end
    end
  end

  // Idle cycles hold the payload bits so the lane does not toggle.
  always_comb begin
    if (state_d == StIdle) phy_data_d = '0;
    else if (hs)           phy_data_d = {1'b1, link.data_i};
    else                   phy_data_d = {1'b0, phy_data_q[width_p-1:0]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      credits_q  <= '0;
      overflow_q <= 1'b0;
      phy_data_q <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
      phy_data_q <= phy_data_d;
      sync1_q    <= link.token_i;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
    end
  end

  assign link.ready_o     = ready;
  assign link.phy_reset_o = (state_q == StIdle) || (state_q == StPhyRst);
  assign link.phy_data_o  = phy_data_q;
  assign link.link_up_o   = active;
  assign link.credits_o   = credits_q;
  assign link.overflow_o  = overflow_q;
endmodule

// File: tb/tb_bsg_link_osdr_tx_ctrl.sv
// Directed bench for bsg_link_osdr_tx_ctrl: bring-up, credit metering, token return,
// clamping, link drop and asynchronous reset, with hand-computed expectations.
module tb_bsg_link_osdr_tx_ctrl;
  localparam int unsigned W = 16;
  localparam int unsigned C = 16;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  bsg_link_osdr_tx_ctrl_if #(.width_p(W), .credits_p(C)) bus ();

  bsg_link_osdr_tx_ctrl #(
    .width_p(W), .credits_p(C), .lg_credit_decimation_p(2),
    .phy_reset_cycles_p(4), .warmup_cycles_p(32)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .link     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe bring-up from the cycle after enable until link_up (bounded).
  task automatic bring_up(input string tag);
    int rc;
    int wc;
    bit badv;
    rc = 0; wc = 0; badv = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.link_up_o) break;
      if (bus.phy_reset_o) rc++;
      else                 wc++;
      if (bus.phy_data_o[W]) badv = 1'b1;
    end
    chk({tag, "_phy_rst_cycles"}, rc, 4);
    chk({tag, "_warmup_cycles"}, wc, 32);
    chk({tag, "_warmup_valid"}, badv, 0);
    chk({tag, "_link_up"}, bus.link_up_o, 1);
    chk({tag, "_credits"}, bus.credits_o, 16);
    chk({tag, "_ready"}, bus.ready_o, 1);
    chk({tag, "_overflow"}, bus.overflow_o, 0);
    chk({tag, "_valid"}, bus.phy_data_o[W], 0);
  endtask

  task automatic token_wait(input string tag, input int exp_credits);
    bus.token_i = ~bus.token_i;
    repeat (3) @(negedge clk);
    chk(tag, bus.credits_o, exp_credits);
  endtask

  initial begin
    reset_n           = 1'b0;
    bus.link_enable_i = 1'b0;
    bus.v_i           = 1'b0;
    bus.data_i        = '0;
    bus.token_i       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phy_reset", bus.phy_reset_o, 1);
    chk("rst_phy_data", bus.phy_data_o, 0);
    chk("rst_ready", bus.ready_o, 0);
    chk("rst_link_up", bus.link_up_o, 0);
    chk("rst_credits", bus.credits_o, 0);
    chk("rst_overflow", bus.overflow_o, 0);

    // 1: bring-up
    reset_n           = 1'b1;
    bus.link_enable_i = 1'b1;
    bring_up("up1");

    // 2: credit exhaustion
    for (int i = 0; i < 16; i++) begin
      bus.v_i    = 1'b1;
      bus.data_i = W'(i);
      @(negedge clk);
      chk("exhaust_data", bus.phy_data_o, {1'b1, W'(i)});
    end
    bus.data_i = 16'h0010;
    chk("exhaust_ready", bus.ready_o, 0);
    chk("exhaust_credits", bus.credits_o, 0);
    @(negedge clk);
    chk("exhaust_stall_data", bus.phy_data_o, 17'h0000F);

    // 3: token return, 3-cycle latency
    bus.token_i = 1'b1;
    @(negedge clk);
    chk("tok_lat1", bus.credits_o, 0);
    @(negedge clk);
    chk("tok_lat2", bus.credits_o, 0);
    @(negedge clk);
    chk("tok_lat3", bus.credits_o, 4);
    chk("tok_ready", bus.ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      bus.data_i = W'(16 + i);
      @(negedge clk);
      chk("tok_send", bus.phy_data_o, {1'b1, W'(16 + i)});
    end
    chk("tok_credits0", bus.credits_o, 0);
    chk("tok_ready0", bus.ready_o, 0);
    bus.v_i = 1'b0;

    // 4: simultaneous handshake and token, then clamp
    token_wait("sim_to4", 4);
    token_wait("sim_to8", 8);
    for (int i = 0; i < 3; i++) begin
      bus.v_i    = 1'b1;
      bus.data_i = W'(16'h0100 + i);
      @(negedge clk);
    end
    bus.v_i = 1'b0;
    chk("sim_at5", bus.credits_o, 5);
    bus.token_i = ~bus.token_i;
    @(negedge clk);
    chk("sim_hold1", bus.credits_o, 5);
    @(negedge clk);
    chk("sim_hold2", bus.credits_o, 5);
    bus.v_i    = 1'b1;
    bus.data_i = 16'hABCD;
    @(negedge clk);
    bus.v_i = 1'b0;
    chk("sim_both", bus.credits_o, 8);
    chk("sim_data", bus.phy_data_o, 17'h1ABCD);
    token_wait("clamp_to12", 12);
    token_wait("clamp_to16", 16);
    chk("clamp_no_ovf", bus.overflow_o, 0);
    bus.v_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.v_i = 1'b0;
    chk("clamp_at14", bus.credits_o, 14);
    token_wait("clamp_sat", 16);
    chk("clamp_ovf", bus.overflow_o, 1);

    // 5: link drop mid-stream
    bus.v_i    = 1'b1;
    bus.data_i = 16'h1111;
    @(negedge clk);
    chk("drop_pre_data", bus.phy_data_o, 17'h11111);
    bus.data_i        = 16'h2222;
    bus.link_enable_i = 1'b0;
    #1;
    chk("drop_ready_now", bus.ready_o, 0);
    @(negedge clk);
    chk("drop_phy_reset", bus.phy_reset_o, 1);
    chk("drop_phy_data", bus.phy_data_o, 0);
    chk("drop_link_up", bus.link_up_o, 0);
    chk("drop_credits", bus.credits_o, 15);
    bus.v_i     = 1'b0;
    bus.token_i = ~bus.token_i;
    repeat (4) @(negedge clk);
    chk("drop_idle_token", bus.credits_o, 15);
    chk("drop_idle_ovf", bus.overflow_o, 1);
    bus.link_enable_i = 1'b1;
    bring_up("up2");

    // 6: asynchronous reset during a send burst
    bus.v_i    = 1'b1;
    bus.data_i = 16'h3333;
    @(negedge clk);
    chk("arst_pre_data", bus.phy_data_o, 17'h13333);
    bus.data_i = 16'h4444;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_phy_reset", bus.phy_reset_o, 1);
    chk("arst_phy_data", bus.phy_data_o, 0);
    chk("arst_ready", bus.ready_o, 0);
    chk("arst_link_up", bus.link_up_o, 0);
    chk("arst_credits", bus.credits_o, 0);
    chk("arst_overflow", bus.overflow_o, 0);
    @(negedge clk);
    bus.v_i = 1'b0;
    reset_n = 1'b1;
    bring_up("up3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
